mux4_scan_seq: RTL and testbench
================================

# mux4_scan_seq

Round-robin scan sequencer that drives the select pair of the 4:1 bit mux (m4) and captures its output. It picks the next requesting channel, holds the selects stable for a programmable settle time, samples `out`, and presents the sampled bit on a valid/ready interface. It sits directly upstream (select side) and downstream (capture side) of m4.

## Interface
- `DWELL`, default 2: settle cycles between select change and capture; legal 1..15, elaboration error otherwise.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `en  in  1`: permits new grants; does not abort a grant in progress.
- `req  in  4`: request per channel; bit k = m4 input i(k+1).
- `mux_out  in  1`: m4 `out`.
- `sel1  out  1`: m4 select MSB.
- `sel2  out  1`: m4 select LSB.
- `smp_data  out  1`: captured mux bit.
- `smp_ch  out  2`: channel index of `smp_data` (0..3).
- `smp_valid  out  1`: sample available.
- `smp_ready  in  1`: consumer accepts sample.
- `busy  out  1`: high in any state other than IDLE.

## Operation
- Select encoding `{sel1,sel2}`: 00→i1, 01→i2, 10→i3, 11→i4; equals channel index.
- States: IDLE, SETTLE, HOLD.
- IDLE: if `en && |req`, grant the first set bit searching ptr+1, ptr+2, ptr+3, ptr+4 (mod 4); register `{sel1,sel2}`=ch and `cnt`=DWELL-1; go SETTLE. Otherwise stay.
- SETTLE: if `cnt==0`, register `smp_data`=`mux_out`, `smp_ch`=ch, `smp_valid`=1; go HOLD. Else `cnt`--.
- HOLD: `smp_valid`, `smp_data`, `smp_ch`, selects stable. On `smp_valid && smp_ready`: `smp_valid`←0, `ptr`←ch, go IDLE.
- `req` sampled only at grant; deassertion during SETTLE/HOLD ignored, capture still happens.
- `en` low: no new grant; current transaction completes normally.
- `smp_ready` while not valid: ignored.
- Selects change only on a grant edge; hold last value in IDLE.
- Reset values: `sel1`=`sel2`=0, `smp_data`=0, `smp_ch`=0, `smp_valid`=0, `busy`=0, state IDLE, `ptr`=3 (first priority ch0), `cnt`=0.
- Reset mid-operation: all of the above on the next edge; pending sample discarded.

## Timing
- Grant at edge t → selects valid after t; capture at edge t+DWELL; `smp_valid` high from t+DWELL.
- `mux_out` must be stable DWELL cycles after select change; capture samples it at the last SETTLE edge.
- Handshake at edge h → IDLE after h; earliest next grant at h+1.
- Sustained throughput with `smp_ready` held high: one sample per DWELL+2 cycles.
- `busy` registered: rises with grant edge, falls with handshake edge.
- No combinational path from any input to any output.

## Structure
- Package `mux4_seq_pkg`: state enum (IDLE/SETTLE/HOLD), `ch_t` (2-bit channel), select-encoding constants CH_I1..CH_I4, DWELL range limits.
- Sub-module `rr_pick4`: combinational round-robin picker; inputs `req[3:0]`, `ptr[1:0]`; outputs `gnt_ch[1:0]`, `any`.
- Top: FSM, dwell counter, capture/output registers.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs → all outputs 0, `busy`=0; first grant afterwards is ch0 when `req`=4'b1111.
- Single channel, DWELL=2: `req`=4'b0001, i1=1 in m4 model → `{sel1,sel2}`=00 after grant edge t, `smp_valid`=1 at t+2, `smp_data`=1, `smp_ch`=0.
- Round robin: `req`=4'b1111, `smp_ready`=1, DWELL=2 → `smp_ch` sequence 0,1,2,3,0, selects 00,01,10,11,00, grants 4 cycles apart.
- Backpressure: `smp_ready`=0 for 5 cycles after valid → `smp_valid`, `smp_data`, `smp_ch`, selects stable; no new grant until handshake edge +1.
- Reset mid-SETTLE (DWELL=4, reset at t+2) → outputs 0 next edge, no `smp_valid`, next grant ch0.
- Enable gating: `en`=0, `req`=4'b1111 for 10 cycles → `busy`=0, selects unchanged; `en` dropped at t+1 during SETTLE → capture still occurs at t+DWELL.

Source files
------------

// File: rtl/mux4_seq_pkg.sv
// Shared types and constants for the m4 scan sequencer: FSM states, channel
// type, select encodings and the legal dwell range.
package mux4_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    typedef logic [1:0] ch_t;

    // {sel1,sel2} value that routes each m4 input to out
    localparam ch_t CH_I1 = 2'd0;
    localparam ch_t CH_I2 = 2'd1;
    localparam ch_t CH_I3 = 2'd2;
    localparam ch_t CH_I4 = 2'd3;

    localparam int DWELL_MIN = 1;
    localparam int DWELL_MAX = 15;
    localparam int CNT_W     = 4;

    // Pointer parked on the last channel so that ch0 wins first after reset
    localparam ch_t PTR_RESET = CH_I4;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requesting channel after ptr,
// searching ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
module rr_pick4
    import mux4_seq_pkg::*;
(
    input  logic [3:0] req,
    input  ch_t        ptr,
    output ch_t        gnt_ch,
    output logic       any
);

    logic [3:0] rot;
    ch_t        off;

    // rot[gi] is the request gi+1 places after ptr
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            localparam ch_t STEP = ch_t'(gi + 1);
            ch_t idx;
            assign idx     = ptr + STEP;
            assign rot[gi] = req[idx];
        end
    endgenerate

    always_comb begin
        off = 2'd3;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        gnt_ch = ptr + off + 2'd1;
        any    = |req;
    end

endmodule

// File: rtl/mux4_scan_seq.sv
// Round-robin scan sequencer for the m4 bit mux: grants a channel, waits
// DWELL cycles for the mux to settle, captures out and offers it valid/ready.
module mux4_scan_seq
    import mux4_seq_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       mux_out,
    output logic       sel1,
    output logic       sel2,
    output logic       smp_data,
    output logic [1:0] smp_ch,
    output logic       smp_valid,
    input  logic       smp_ready,
    output logic       busy
);

    generate
        if (DWELL < DWELL_MIN || DWELL > DWELL_MAX) begin : g_dwell_check
            $error("mux4_scan_seq: DWELL must be within 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    state_t           state_reg, state_next;
    ch_t              ptr_reg, ptr_next;
    ch_t              sel_reg, sel_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             smp_data_reg, smp_data_next;
    ch_t              smp_ch_reg, smp_ch_next;
    logic             smp_valid_reg, smp_valid_next;

    ch_t  gnt_ch;
    logic any;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .gnt_ch (gnt_ch),
        .any    (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= PTR_RESET;
            sel_reg       <= CH_I1;
            cnt_reg       <= '0;
            smp_data_reg  <= 1'b0;
            smp_ch_reg    <= CH_I1;
            smp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            sel_reg       <= sel_next;
            cnt_reg       <= cnt_next;
            smp_data_reg  <= smp_data_next;
            smp_ch_reg    <= smp_ch_next;
            smp_valid_reg <= smp_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        sel_next       = sel_reg;
        cnt_next       = cnt_reg;
        smp_data_next  = smp_data_reg;
        smp_ch_next    = smp_ch_reg;
        smp_valid_next = smp_valid_reg;
        case (state_reg)
            IDLE: begin
                if (en && any) begin
                    sel_next   = gnt_ch;
                    cnt_next   = CNT_LOAD;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                // req and en are deliberately not looked at once granted
                if (cnt_reg == '0) begin
                    smp_data_next  = mux_out;
                    smp_ch_next    = sel_reg;
                    smp_valid_next = 1'b1;
                    state_next     = HOLD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            HOLD: begin
                if (smp_valid_reg && smp_ready) begin
                    smp_valid_next = 1'b0;
                    ptr_next       = sel_reg;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign {sel1, sel2} = sel_reg;
    assign smp_data     = smp_data_reg;
    assign smp_ch       = smp_ch_reg;
    assign smp_valid    = smp_valid_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_mux4_scan_seq.sv
// Self-checking bench for mux4_scan_seq: randomized transactions checked
// against a transaction-level round-robin model with an m4 mux model.
module tb_mux4_scan_seq;

    localparam int D  = 2;
    localparam int D4 = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DWELL=2 instance
    logic       rst, en, mux_out, smp_ready;
    logic [3:0] req, mux_in;
    logic       sel1, sel2, smp_data, smp_valid, busy;
    logic [1:0] smp_ch;
    logic [6:0] obs;

    // DWELL=4 instance, used for the reset-in-SETTLE scenario
    logic       rst4, en4, mux_out4, rdy4;
    logic [3:0] req4, mux_in4;
    logic       sel1_4, sel2_4, smp_data4, smp_valid4, busy4;
    logic [1:0] smp_ch4;
    logic [6:0] obs4;

    assign mux_out  = mux_in[{sel1, sel2}];
    assign mux_out4 = mux_in4[{sel1_4, sel2_4}];
    assign obs      = {busy, sel1, sel2, smp_valid, smp_data, smp_ch};
    assign obs4     = {busy4, sel1_4, sel2_4, smp_valid4, smp_data4, smp_ch4};

    mux4_scan_seq #(.DWELL(D)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .mux_out(mux_out),
        .sel1(sel1), .sel2(sel2), .smp_data(smp_data), .smp_ch(smp_ch),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .busy(busy)
    );

    mux4_scan_seq #(.DWELL(D4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .req(req4), .mux_out(mux_out4),
        .sel1(sel1_4), .sel2(sel2_4), .smp_data(smp_data4), .smp_ch(smp_ch4),
        .smp_valid(smp_valid4), .smp_ready(rdy4), .busy(busy4)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Transaction-level model state
    int         exp_ptr;
    logic       exp_data;
    logic [1:0] exp_ch;
    logic [1:0] exp_sel;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (p + k) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_ptr  = 3;
        exp_data = 1'b0;
        exp_ch   = 2'd0;
        exp_sel  = 2'd0;
    endtask

    // One full grant/settle/capture/hold/handshake sequence on the DWELL=2 DUT.
    task automatic do_txn(input logic [3:0] r, input logic [3:0] mval, input int delay,
                          input bit drop_en, output int gnt_cyc, output int ch);
        int         c;
        logic [6:0] e;
        mux_in    = mval;
        req       = r;
        en        = 1'b1;
        smp_ready = 1'($urandom);
        c         = pick(r, exp_ptr);
        cyc();
        gnt_cyc = cycle;
        exp_sel = 2'(c);
        e = {1'b1, exp_sel, 1'b0, exp_data, exp_ch};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL grant: got %b expected %b (req=%b)", obs, e, r);
        end
        for (int k = 1; k < D; k++) begin
            req = 4'($urandom); en = drop_en ? 1'b0 : 1'($urandom); smp_ready = 1'($urandom);
            cyc();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL settle: got %b expected %b", obs, e);
            end
        end
        req = 4'($urandom); en = drop_en ? 1'b0 : 1'($urandom); smp_ready = 1'($urandom);
        cyc();
        exp_data = mux_in[c];
        exp_ch   = 2'(c);
        e = {1'b1, exp_sel, 1'b1, exp_data, exp_ch};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL capture: got %b expected %b (mux_in=%b)", obs, e, mux_in);
        end
        for (int k = 0; k < delay; k++) begin
            smp_ready = 1'b0; en = 1'b1; req = 4'($urandom_range(1, 15));
            cyc();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL hold_stable: got %b expected %b", obs, e);
            end
        end
        smp_ready = 1'b1;
        en        = 1'b0;
        cyc();
        exp_ptr = c;
        e = {1'b0, exp_sel, 1'b0, exp_data, exp_ch};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL handshake: got %b expected %b", obs, e);
        end
        smp_ready = 1'b0;
        ch = c;
    endtask

    task automatic apply_reset();
        rst = 1'b1; en = 1'($urandom); req = 4'($urandom);
        smp_ready = 1'($urandom); mux_in = 4'($urandom);
        repeat (2) cyc();
        model_reset();
        rst = 1'b0; en = 1'b0; req = 4'd0; smp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int g, c;
        apply_reset();
        n_checks++;
        if (obs !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 7'd0);
        end
        do_txn(4'b1111, 4'($urandom), 0, 1'b0, g, c);
        n_checks++;
        if (c !== 0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got ch%0d expected ch0", c);
        end
    endtask

    task automatic test_single();
        int g, c;
        do_txn(4'b0001, 4'b0001, 0, 1'b0, g, c);
        n_checks++;
        if ({smp_data, smp_ch} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_channel: got data=%b ch=%0d expected data=1 ch=0", smp_data, smp_ch);
        end
    endtask

    task automatic test_round_robin();
        int g, c, prev_g;
        apply_reset();
        prev_g = 0;
        for (int k = 0; k < 5; k++) begin
            do_txn(4'b1111, 4'($urandom), 0, 1'b0, g, c);
            n_checks++;
            if (c !== k % 4) begin
                n_fail++;
                $display("FAIL rr_order: txn %0d got ch%0d expected ch%0d", k, c, k % 4);
            end
            if (k > 0) begin
                n_checks++;
                if (g - prev_g !== D + 2) begin
                    n_fail++;
                    $display("FAIL rr_spacing: got %0d cycles expected %0d", g - prev_g, D + 2);
                end
            end
            prev_g = g;
        end
    endtask

    task automatic test_backpressure();
        int g, c;
        for (int k = 0; k < 3; k++)
            do_txn(4'($urandom_range(1, 15)), 4'($urandom), 5, 1'b0, g, c);
    endtask

    task automatic test_enable();
        int g, c;
        logic [6:0] e;
        e = {1'b0, exp_sel, 1'b0, exp_data, exp_ch};
        for (int k = 0; k < 10; k++) begin
            en = 1'b0; req = 4'b1111; smp_ready = 1'($urandom);
            cyc();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL enable_gate: got %b expected %b", obs, e);
            end
        end
        do_txn(4'($urandom_range(1, 15)), 4'($urandom), 1, 1'b1, g, c);
    endtask

    task automatic test_random();
        int g, c;
        for (int k = 0; k < 40; k++)
            do_txn(4'($urandom_range(1, 15)), 4'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom), g, c);
    endtask

    task automatic test_reset_mid_settle();
        logic [6:0] e;
        rst4 = 1'b0; req4 = 4'b0010; en4 = 1'b1; mux_in4 = 4'($urandom);
        cyc();
        e = {1'b1, 2'd1, 1'b0, 1'b0, 2'd0};
        n_checks++;
        if (obs4 !== e) begin
            n_fail++;
            $display("FAIL mid_reset_grant: got %b expected %b", obs4, e);
        end
        req4 = 4'd0; en4 = 1'b0;
        cyc();
        rst4 = 1'b1;
        cyc();
        n_checks++;
        if (obs4 !== 7'd0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got %b expected %b", obs4, 7'd0);
        end
        rst4 = 1'b0; rdy4 = 1'($urandom);
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_checks++;
            if (obs4 !== 7'd0) begin
                n_fail++;
                $display("FAIL mid_reset_no_sample: got %b expected %b", obs4, 7'd0);
            end
        end
        req4 = 4'b1111; en4 = 1'b1; rdy4 = 1'b0;
        cyc();
        en4 = 1'b0;
        repeat (D4 - 1) cyc();
        n_checks++;
        if (obs4 !== 7'b1000000) begin
            n_fail++;
            $display("FAIL mid_reset_settle4: got %b expected %b", obs4, 7'b1000000);
        end
        cyc();
        e = {1'b1, 2'd0, 1'b1, mux_in4[0], 2'd0};
        n_checks++;
        if (obs4 !== e) begin
            n_fail++;
            $display("FAIL mid_reset_regrant_ch0: got %b expected %b", obs4, e);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 4'd0; smp_ready = 1'b0; mux_in = 4'd0;
        rst4 = 1'b1; en4 = 1'b0; req4 = 4'd0; rdy4 = 1'b0; mux_in4 = 4'd0;
        model_reset();
        cyc();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_enable();
        test_random();
        test_reset_mid_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
